// File: rtl/spi_cmd.sv
// SPI command parser: turns the spi_byte stream into bus read/write requests
// and returns read data as the next byte shifted out to the host.
module spi_cmd #(
    parameter int unsigned ADDR_WIDTH = 17
) (
    input  logic                  sys_clk,
    input  logic                  sys_reset_n,
    input  logic                  spi_cs_n,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    output logic [7:0]            tx_byte,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [7:0]            bus_wr_data,
    input  logic [7:0]            bus_rd_data,
    input  logic                  bus_ack,
    output logic                  overrun
);

    localparam int unsigned HI_W = ADDR_WIDTH - 16;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_DATA,
        ST_BUS
    } state_t;

    state_t state;
    logic   cs_meta;
    logic   cs_sync;
    logic   wr_cmd;
    logic   rx_take;

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            cs_meta <= 1'b1;
            cs_sync <= 1'b1;
        end else begin
            cs_meta <= spi_cs_n;
            cs_sync <= cs_meta;
        end
    end

    // Bytes strobed while the frame is deselected never reach the parser.
    always_comb begin
        rx_take = rx_valid && !cs_sync;
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state       <= ST_CMD;
            wr_cmd      <= 1'b0;
            tx_byte     <= '0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            overrun     <= 1'b0;
        end else begin
            case (state)
                ST_CMD: begin
                    if (rx_take) begin
                        overrun <= 1'b0;
                        wr_cmd  <= rx_byte[7];
                        if (rx_byte[6]) begin
                            bus_addr[ADDR_WIDTH-1:16] <= rx_byte[HI_W-1:0];
                            state <= ST_ADDR_HI;
                        end else if (rx_byte[7]) begin
                            state <= ST_DATA;
                        end else begin
                            bus_we  <= 1'b0;
                            bus_req <= 1'b1;
                            state   <= ST_BUS;
                        end
                    end
                end
                ST_ADDR_HI: begin
                    if (cs_sync) begin
                        state <= ST_CMD;
                    end else if (rx_valid) begin
                        bus_addr[15:8] <= rx_byte;
                        state <= ST_ADDR_LO;
                    end
                end
                ST_ADDR_LO: begin
                    if (cs_sync) begin
                        state <= ST_CMD;
                    end else if (rx_valid) begin
                        bus_addr[7:0] <= rx_byte;
                        if (wr_cmd) begin
                            state <= ST_DATA;
                        end else begin
                            bus_we  <= 1'b0;
                            bus_req <= 1'b1;
                            state   <= ST_BUS;
                        end
                    end
                end
                ST_DATA: begin
                    if (cs_sync) begin
                        state <= ST_CMD;
                    end else if (rx_valid) begin
                        bus_wr_data <= rx_byte;
                        bus_we      <= 1'b1;
                        bus_req     <= 1'b1;
                        state       <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    // A deselect here does not abort: the request runs to its ack.
                    if (rx_take) begin
                        overrun <= 1'b1;
                    end
                    if (bus_ack) begin
                        bus_req  <= 1'b0;
                        bus_addr <= bus_addr + ADDR_WIDTH'(1);
                        if (!bus_we) begin
                            tx_byte <= bus_rd_data;
                        end
                        state <= ST_CMD;
                    end
                end
                default: state <= ST_CMD;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd.sv
// Scoreboard bench for spi_cmd: frame-level host model feeds expected bus
// transactions to a monitor that checks and acknowledges them.
module tb_spi_cmd;

    logic        sys_clk;
    logic        sys_reset_n;
    logic        spi_cs_n;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [7:0]  tx_byte;
    logic        bus_req;
    logic        bus_we;
    logic [16:0] bus_addr;
    logic [7:0]  bus_wr_data;
    logic [7:0]  bus_rd_data;
    logic        bus_ack;
    logic        overrun;

    spi_cmd #(.ADDR_WIDTH(17)) dut (
        .sys_clk     (sys_clk),
        .sys_reset_n (sys_reset_n),
        .spi_cs_n    (spi_cs_n),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .tx_byte     (tx_byte),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_rd_data (bus_rd_data),
        .bus_ack     (bus_ack),
        .overrun     (overrun)
    );

    typedef struct {
        logic        we;
        logic [16:0] addr;
        logic [7:0]  wd;
        logic [7:0]  rd;
        int unsigned delay;
    } txn_t;

    txn_t        exp_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned done_cnt = 0;

    // host-side model of the target
    logic [16:0] m_addr = '0;
    logic [7:0]  m_tx = '0;
    logic        m_ovr = 1'b0;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expected transaction when a request appears, acks it.
    initial begin
        txn_t e;
        bit   held;
        bit   aborted;
        bus_ack     = 1'b0;
        bus_rd_data = '0;
        forever begin
            @(negedge sys_clk);
            if (sys_reset_n && bus_req) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_req", exp_q.size(), 1);
                    bus_ack = 1'b1;
                    @(posedge sys_clk); #1;
                    bus_ack = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                    chk("req_we", bus_we, e.we);
                    chk("req_addr", bus_addr, e.addr);
                    if (e.we) chk("req_wr_data", bus_wr_data, e.wd);
                    held = 1'b1;
                    aborted = 1'b0;
                    for (int unsigned i = 0; i < e.delay; i++) begin
                        @(posedge sys_clk); #1;
                        if (!sys_reset_n) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (!bus_req || bus_addr !== e.addr || bus_we !== e.we) held = 1'b0;
                        bus_rd_data = 8'($urandom);
                    end
                    if (!aborted) begin
                        chk("req_held", held, 1);
                        bus_ack     = 1'b1;
                        bus_rd_data = e.rd;
                        @(posedge sys_clk); #1;
                        bus_ack     = 1'b0;
                        bus_rd_data = 8'($urandom);
                        done_cnt++;
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge sys_clk); #1;
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge sys_clk); #1;
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
    endtask

    task automatic wait_req();
        int unsigned t = 0;
        do begin
            @(negedge sys_clk);
            t++;
        end while (!bus_req && t < 50);
    endtask

    // abort_after: 0 = full frame, else raise CS_N after that many bytes.
    // ovr_at: cycles after the request appears to strobe a stray byte (-1 = none).
    task automatic run_frame(input logic [7:0] cmd, input logic [15:0] a, input logic [7:0] wd,
                             input int unsigned delay, input int unsigned abort_after,
                             input int ovr_at, input bit cs_in_bus);
        logic [7:0]  bytes[$];
        int unsigned nb;
        int unsigned sent;
        int unsigned start;
        int unsigned t;
        logic [7:0]  rd;
        txn_t        e;
        bytes.push_back(cmd);
        if (cmd[6]) begin
            bytes.push_back(a[15:8]);
            bytes.push_back(a[7:0]);
        end
        if (cmd[7]) bytes.push_back(wd);
        nb   = bytes.size();
        sent = (abort_after != 0 && abort_after < nb) ? abort_after : nb;
        if (cmd[6]) begin
            m_addr[16] = cmd[0];
            if (sent >= 2) m_addr[15:8] = a[15:8];
            if (sent >= 3) m_addr[7:0] = a[7:0];
        end
        m_ovr = 1'b0;
        rd = 8'($urandom);
        if (sent == nb) begin
            e = '{we: cmd[7], addr: m_addr, wd: wd, rd: rd, delay: delay};
            exp_q.push_back(e);
        end
        if (spi_cs_n) begin
            spi_cs_n = 1'b0;
            repeat (3) @(posedge sys_clk);
        end
        start = done_cnt;
        for (int unsigned i = 0; i < sent; i++) begin
            send_byte(bytes[i]);
            if (i + 1 < sent) repeat ($urandom_range(0, 3)) @(posedge sys_clk);
        end
        if (sent < nb) begin
            @(negedge sys_clk);
            spi_cs_n = 1'b1;
            repeat (6) @(negedge sys_clk);
            chk("abort_no_req", bus_req, 0);
            chk("abort_addr", bus_addr, m_addr);
            chk("abort_overrun", overrun, m_ovr);
            return;
        end
        if (cs_in_bus) begin
            wait_req();
            spi_cs_n = 1'b1;
        end else if (ovr_at >= 0) begin
            wait_req();
            repeat (ovr_at) begin
                @(posedge sys_clk); #1;
            end
            rx_byte  = 8'($urandom);
            rx_valid = 1'b1;
            @(posedge sys_clk); #1;
            rx_valid = 1'b0;
            m_ovr = 1'b1;
        end
        t = 0;
        while (done_cnt == start && t < 300) begin
            @(negedge sys_clk);
            t++;
        end
        chk("txn_done", done_cnt - start, 1);
        m_addr = m_addr + 17'd1;
        if (!cmd[7]) m_tx = rd;
        chk("post_req_low", bus_req, 0);
        chk("post_addr", bus_addr, m_addr);
        chk("post_tx_byte", tx_byte, m_tx);
        chk("post_overrun", overrun, m_ovr);
    endtask

    initial begin
        logic [7:0]  c;
        int unsigned nb;
        int unsigned dly;
        int unsigned ab;
        int          ov;
        bit          csb;
        sys_reset_n = 1'b0;
        spi_cs_n    = 1'b1;
        rx_byte     = '0;
        rx_valid    = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_wr_data", bus_wr_data, 0);
        chk("rst_overrun", overrun, 0);
        sys_reset_n = 1'b1;

        run_frame(8'hC1, 16'h2345, 8'hA5, 3, 0, -1, 0);
        run_frame(8'h40, 16'h8000, 8'h00, 2, 0, -1, 0);
        run_frame(8'h00, 16'h0000, 8'h00, 0, 0, -1, 0);
        run_frame(8'hC1, 16'hFFFF, 8'h11, 1, 0, -1, 0);
        run_frame(8'h80, 16'h0000, 8'h22, 2, 0, -1, 0);
        run_frame(8'hC1, 16'h2399, 8'h77, 1, 2, -1, 0);
        run_frame(8'h40, 16'h0010, 8'h00, 1, 0, -1, 0);
        run_frame(8'h40, 16'h1234, 8'h00, 20, 0, -1, 1);
        run_frame(8'h80, 16'h0000, 8'h5A, 4, 0, 2, 0);
        run_frame(8'h00, 16'h0000, 8'h00, 3, 0, 3, 0);
        run_frame(8'h00, 16'h0000, 8'h00, 1, 0, -1, 0);

        for (int unsigned n = 0; n < 60; n++) begin
            c   = 8'($urandom);
            nb  = 1 + (c[6] ? 2 : 0) + (c[7] ? 1 : 0);
            dly = $urandom_range(0, 6);
            ab  = 0;
            ov  = -1;
            csb = 1'b0;
            if (nb > 1 && $urandom_range(0, 5) == 0) ab = $urandom_range(1, nb - 1);
            else if ($urandom_range(0, 7) == 0) begin
                csb = 1'b1;
                dly = $urandom_range(20, 25);
            end else if ($urandom_range(0, 4) == 0) ov = int'($urandom_range(0, dly));
            run_frame(c, 16'($urandom), 8'($urandom), dly, ab, ov, csb);
        end

        // Asynchronous reset while a write is waiting for its ack.
        if (spi_cs_n) begin
            spi_cs_n = 1'b0;
            repeat (3) @(posedge sys_clk);
        end
        m_addr = 17'h01234;
        exp_q.push_back('{we: 1'b1, addr: 17'h01234, wd: 8'h56, rd: 8'h00, delay: 40});
        send_byte(8'hC0);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        wait_req();
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk); #2;
        sys_reset_n = 1'b0;
        #1;
        chk("arst_bus_req", bus_req, 0);
        chk("arst_bus_we", bus_we, 0);
        chk("arst_bus_addr", bus_addr, 0);
        chk("arst_wr_data", bus_wr_data, 0);
        chk("arst_tx_byte", tx_byte, 0);
        chk("arst_overrun", overrun, 0);
        repeat (3) @(negedge sys_clk);
        sys_reset_n = 1'b1;
        m_addr = '0;
        m_tx   = '0;
        m_ovr  = 1'b0;
        repeat (3) @(posedge sys_clk);
        run_frame(8'h00, 16'h0000, 8'h00, 2, 0, -1, 0);

        repeat (5) @(negedge sys_clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
